led_frame_sequencer: RTL
========================

Name: led_frame_sequencer

Overview:
- Double-buffered frame controller for the 6x6 LED matrix scanner.
- A producer writes rows into a hidden back buffer through a valid/ready handshake, then requests a commit.
- The block swaps back and front buffers only at a frame boundary, detected from the scanner's row index, so the display never tears.
- The front buffer drives the scanner's 36-bit img input: pixel n at bit n, row r at bits [6r+5:6r].

Parameters:
- DIM_X, 6, pixels per row (column count).
- DIM_Y, 6, rows per frame.
- ROW_W, 3, width of row address and scan-row index; must satisfy 2^ROW_W >= DIM_Y.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- wr_valid  input  1  producer has a row write.
- wr_ready  output  1  block accepts the row write this cycle.
- wr_row  input  ROW_W  target row, 0..DIM_Y-1.
- wr_data  input  DIM_X  row pixels, bit 0 = leftmost, 1 = lit.
- clear  input  1  single-cycle pulse: zero the back buffer.
- commit_req  input  1  single-cycle pulse: publish the back buffer at the next frame boundary.
- commit_ack  output  1  single-cycle pulse in the cycle after the swap.
- busy  output  1  high while a commit is pending.
- scan_row  input  ROW_W  current row index from the matrix scanner.
- img  output  DIM_X*DIM_Y  front buffer to the scanner.

Behaviour:
- Reset is asynchronous, active-low. When rst_n is low, all of the following are cleared:
  - front and back buffers = 0, so img = 0;
  - state = IDLE;
  - wr_ready = 0, commit_ack = 0, busy = 0;
  - scan_row history register = 0.
- wr_ready is registered. It rises the first cycle after reset is released.
- States and transitions:
  - IDLE: wr_ready = 1.
    - A write with wr_valid & wr_ready and wr_row < DIM_Y stores wr_data into back row wr_row on that clock edge.
    - A write with wr_row >= DIM_Y is accepted and discarded.
    - commit_req -> PEND.
  - PEND: wr_ready = 0 and busy = 1. Wait for a frame boundary.
    - Boundary: previous-cycle scan_row == DIM_Y-1 and current scan_row == 0. This is sampled every clk.
    - On a boundary -> SWAP.
  - SWAP (1 cycle): front <= back and the back buffer is retained, so a commit is incremental. Then go to IDLE with commit_ack = 1 for exactly that next cycle.
- Swap timing: img changes on the first clk edge after the boundary cycle is detected. It is stable at all other times.
- Simultaneous events in IDLE:
  - Write and commit_req in the same cycle: the write is applied first and is included in the commit.
  - clear and a write in the same cycle: clear wins and that row data is lost.
  - clear and commit_req in the same cycle: the clear is applied and the commit publishes the cleared buffer.
- commit_req while in PEND or SWAP is ignored; no second ack is produced.
- clear while in PEND or SWAP is ignored. The pending frame is protected.
- A boundary detected in IDLE has no effect.
- scan_row values >= DIM_Y never form a boundary.
- If scan_row jumps DIM_Y-1 -> 0 in the very cycle commit_req arrives, that boundary does not count; the swap waits for the next one.
- Reset mid-PEND abandons the commit: no ack, and img = 0.
- Latency:
  - commit_req to commit_ack is at least 2 cycles.
  - Worst case is one full scan frame plus 2 cycles.
- All buffers are plain flops; no inferred RAM.

Test Plan:
- Reset release -> img = 0, busy = 0, commit_ack = 0; wr_ready = 1 from the 2nd cycle.
- Write row 0 = 6'b000001 and row 5 = 6'b100000, then commit_req; scan_row walks 0..5 then 0 -> img = 36'h8_0000_0001 one edge after the 5->0 cycle; commit_ack pulses once; img unchanged before the swap.
- During PEND, assert wr_valid with row 2 = 6'h3F -> wr_ready = 0, no write is accepted, and row 2 of img stays 0 after the swap. After the ack, the write is accepted when re-presented.
- Write, then clear and commit_req in the same cycle -> after the boundary, img = 0 and commit_ack = 1.
- Second commit_req while busy, plus scan_row held at 3 for 100 cycles -> busy stays 1, no ack; one ack after the next 5->0 transition. Out-of-range wr_row = 6 is accepted and img is unchanged.
- Pull rst_n low mid-PEND with a nonzero back buffer -> immediate img = 0 and busy = 0; no commit_ack after release.

Source files
------------

// File: rtl/led_frame_sequencer_if.sv
// led_frame_sequencer_if: producer and scanner signal bundle for led_frame_sequencer
interface led_frame_sequencer_if #(parameter int DIM_X = 6, DIM_Y = 6, ROW_W = 3);
  logic wr_valid, wr_ready, clear, commit_req, commit_ack, busy;
  logic [ROW_W-1:0] wr_row, scan_row;
  logic [DIM_X-1:0] wr_data;
  logic [DIM_X*DIM_Y-1:0] img;
  modport master(output wr_valid, wr_row, wr_data, clear, commit_req, scan_row,
                 input wr_ready, commit_ack, busy, img);
  modport slave(input wr_valid, wr_row, wr_data, clear, commit_req, scan_row,
                output wr_ready, commit_ack, busy, img);
endinterface

// File: rtl/led_frame_sequencer.sv
// led_frame_sequencer: double-buffered LED frame store that swaps buffers only at a scan frame boundary
module led_frame_sequencer #(parameter int DIM_X = 6, DIM_Y = 6, ROW_W = 3) (
  input logic clk,
  input logic rst_n,
  led_frame_sequencer_if.slave bus
);
  localparam logic [ROW_W-1:0] LAST = ROW_W'(DIM_Y - 1);
  typedef enum logic [1:0] {IDLE, PEND, SWAP} state_t;
  state_t r_state, w_next;
  logic [ROW_W-1:0] r_prev_row;
  logic r_wr_ready, r_ack;
  logic [DIM_X-1:0] r_back [DIM_Y];
  logic [DIM_X-1:0] r_front [DIM_Y];
  logic w_idle, w_boundary, w_wr, w_swap;
  assign w_idle = r_state == IDLE;
  assign w_boundary = r_prev_row == LAST && bus.scan_row == '0;
  assign w_wr = w_idle && bus.wr_valid && r_wr_ready && !bus.clear && bus.wr_row <= LAST;
  assign w_swap = r_state == PEND && w_boundary;
  always_comb begin
    w_next = r_state;
    if (w_idle && bus.commit_req) w_next = PEND;
    if (w_swap) w_next = SWAP;
    if (r_state == SWAP) w_next = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_wr_ready <= 1'b0;
      r_ack <= 1'b0;
      r_prev_row <= '0;
    end else begin
      r_state <= w_next;
      r_wr_ready <= w_next == IDLE;
      r_ack <= r_state == SWAP;
      r_prev_row <= bus.scan_row;
    end
  end
  // Front is loaded on the boundary edge itself, so img moves one edge after the 5->0 cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < DIM_Y; r++) begin
        r_back[r] <= '0;
        r_front[r] <= '0;
      end
    end else begin
      for (int r = 0; r < DIM_Y; r++) begin
        if (w_idle && bus.clear) r_back[r] <= '0;
        else if (w_wr && bus.wr_row == ROW_W'(r)) r_back[r] <= bus.wr_data;
        if (w_swap) r_front[r] <= r_back[r];
      end
    end
  end
  for (genvar g = 0; g < DIM_Y; g++) begin : g_img
    assign bus.img[g*DIM_X +: DIM_X] = r_front[g];
  end
  assign bus.wr_ready = r_wr_ready;
  assign bus.commit_ack = r_ack;
  assign bus.busy = !w_idle;
endmodule
